rvfi_commit_sequencer: RTL and testbench
========================================

# rvfi_commit_sequencer

Multi-port RVFI commit serializer for the CVA6 testbench. Each cycle it captures the up to NR_COMMIT_PORTS retired or trapped entries from the core's RVFI bus and queues them in program order (ascending port index). It then replays them one per handshake to a single-port trace or checker consumer, tagging each entry with a 64-bit sequence number. When enabled, a small FSM detects the tohost termination write, stops ingress, drains the queue and flags completion with the exit code.

## Interface
Parameters:
- NR_COMMIT_PORTS, 2: RVFI commit ports sampled per cycle, 1..4.
- DEPTH, 8: queue entries; power of two and ≥ NR_COMMIT_PORTS.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rvfi_i  in  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  commit bus from the core.
- tohost_addr_i  in  riscv::XLEN  tohost address; 0 disables termination detection.
- trace_valid_o  out  1  head entry is available.
- trace_ready_i  in  1  consumer accepts the head entry.
- trace_o  out  rvfi_pkg::rvfi_instr_t  head entry.
- trace_port_o  out  8  commit port index the head entry came from.
- trace_seq_o  out  64  sequence number of the head entry.
- overflow_o  out  1  sticky: a commit group was dropped.
- done_o  out  1  sticky: termination observed and queue drained.
- exit_code_o  out  riscv::XLEN  value written to tohost.

## Operation
- Ingress candidates are ports with rvfi_i[k].valid or rvfi_i[k].trap. Candidate count C is 0..NR_COMMIT_PORTS.
- Free slots F = DEPTH − count, using the count before this cycle's pop, so the check is conservative.
- If C ≤ F, the candidates are written to consecutive slots in ascending k.
- If C > F, the whole group is dropped (no partial write) and overflow_o is set; it stays set until reset.
- Egress is first-word-fall-through: trace_valid_o = (count ≠ 0), and trace_o/trace_port_o show the head slot.
- A pop happens when trace_valid_o && trace_ready_i. Push and pop in the same cycle are both allowed.
- trace_seq_o is a 64-bit count of pops so far, so the first entry popped shows seq 0.
- Termination FSM (only with the macro), states RUN → DRAIN → DONE:
  - A terminating entry is written into the queue this cycle and satisfies all of: valid=1; insn is a store word/dword (insn[6:0]=0100011 with insn[14:12]∈{010,011}, or insn[1:0]=00 with insn[15:13]=110, or insn[15:13]=111 when XLEN=64); mem_addr==tohost_addr_i; mem_wmask≠0; mem_wdata≠0; mem_wdata[0]=1; tohost_addr_i≠0.
  - RUN → DRAIN on a terminating entry. If several ports terminate in the same cycle, the lowest k wins. exit_code_o latches that entry's mem_wdata.
  - In the DRAIN cycle, higher-index candidates of the same group are not written. From DRAIN onward every later group is discarded without setting overflow.
  - DRAIN → DONE when count == 0, after the terminating entry has been popped.
  - DONE is terminal: done_o=1 until reset.

## Timing
- Reset values: trace_valid_o=0, trace_o='0, trace_port_o=0, trace_seq_o=0, overflow_o=0, done_o=0, exit_code_o=0, pointers and count 0, FSM in RUN.
- Latency: an entry presented at edge N is at the output after edge N, i.e. 1 cycle, provided the queue was empty.
- Throughput: one pop per cycle.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally. count is $clog2(DEPTH)+1 bits; next count = count + written − popped.
- Full queue with a simultaneous pop: F=0, so the group is dropped even though a slot frees up that cycle.
- trace_valid_o may be asserted while trace_ready_i=0. The head entry stays stable until it is popped.
- done_o rises on the edge after the pop that empties the queue in DRAIN.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and queued entries are lost.

## Configuration
- RVFI_SEQ_TOHOST_EN defined: the termination FSM is present as described above.
- RVFI_SEQ_TOHOST_EN not defined: no FSM. done_o=0 and exit_code_o=0 permanently, tohost_addr_i is ignored, and ingress is never gated.

## Structure
- rvfi_pkg holds:
  - rvfi_seq_entry_t: instr of type rvfi_instr_t plus an 8-bit port field.
  - rvfi_seq_state_e: RUN, DRAIN, DONE.
- One sub-module, rvfi_seq_fifo: a DEPTH-entry multi-write (up to NR_COMMIT_PORTS per cycle), single-read FWFT queue. It exposes count and a group-write enable.
- The top level contains only candidate compaction, the overflow/seq logic and the FSM.

## Test plan
- Single port 0 commit (valid=1, pc 0x80000000), ready=1 → next cycle valid=1, port=0, seq=0; one cycle later valid=0.
- Ports 0 and 1 both valid in one cycle (pc 0x1000, 0x1004), ready held 0 for 3 cycles then 1 → outputs 0x1000 (seq 0) then 0x1004 (seq 1); the head stays stable while stalled.
- DEPTH=8, ready=0, 5 cycles of 2-port groups → the first 4 groups fill the queue (count=8); the 5th is dropped and overflow_o=1; draining yields exactly 8 entries with seq 0..7.
- Macro on, tohost_addr_i=0x80001000, port 0 SD with mem_wdata=0x1 and port 1 valid in the same cycle → exit_code_o=0x1; the port 1 entry is never output; done_o=1 the cycle after the SD entry is popped.
- Macro on, store to tohost with mem_wdata=0x2, or tohost_addr_i=0 → no termination; done_o stays 0.
- Reset pulsed with 3 entries queued → all outputs return to reset values at once; a new commit then gets seq 0.

Source files
------------

// File: rtl/rvfi_commit_sequencer_pkg.sv
// Shared types for the RVFI commit sequencer: a minimal riscv package providing XLEN,
// and rvfi_pkg with the RVFI record, the queue entry and the termination FSM states.
package riscv;
   localparam int unsigned XLEN = 64;
endpackage

package rvfi_pkg;
   localparam int unsigned XLEN = riscv::XLEN;

   typedef struct packed {
      logic            valid;
      logic [63:0]     order;
      logic [31:0]     insn;
      logic            trap;
      logic [XLEN-1:0] cause;
      logic            halt;
      logic            intr;
      logic [1:0]      mode;
      logic [1:0]      ixl;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [XLEN-1:0] rs1_rdata;
      logic [XLEN-1:0] rs2_rdata;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
      logic [XLEN-1:0] pc_rdata;
      logic [XLEN-1:0] pc_wdata;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN/8-1:0] mem_rmask;
      logic [XLEN/8-1:0] mem_wmask;
      logic [XLEN-1:0] mem_rdata;
      logic [XLEN-1:0] mem_wdata;
   } rvfi_instr_t;

   typedef struct packed {
      rvfi_instr_t instr;
      logic [7:0]  port;
   } rvfi_seq_entry_t;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} rvfi_seq_state_e;
endpackage

// File: rtl/rvfi_seq_fifo.sv
// First-word-fall-through queue accepting up to NR_COMMIT_PORTS entries per cycle
// (already compacted into wr_data[0..wr_num-1]) and releasing one entry per pop.
module rvfi_seq_fifo
   import rvfi_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned DEPTH           = 8,
   localparam int unsigned PW             = $clog2(DEPTH),
   localparam int unsigned CW             = $clog2(DEPTH) + 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   wr_en,
   input  logic [CW-1:0]                          wr_num,
   input  rvfi_seq_entry_t [NR_COMMIT_PORTS-1:0]  wr_data,
   input  logic                                   rd_en,
   output rvfi_seq_entry_t                        rd_data,
   output logic [CW-1:0]                          count
);

   rvfi_seq_entry_t mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   wr_cnt;
   logic            pop;

   assign wr_cnt = wr_en ? wr_num : '0;
   assign pop    = rd_en && (count != '0);

   // Storage is not reset; the head is masked to zero while empty instead.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
         if (wr_en && (CW'(i) < wr_num)) begin
            mem[wr_ptr + PW'(i)] <= wr_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(wr_cnt);
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + wr_cnt - CW'(pop);
      end
   end

   assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rvfi_commit_sequencer.sv
// Serializes multi-port RVFI commits into one sequence-numbered trace stream.
// Optional tohost termination FSM is built when RVFI_SEQ_TOHOST_EN is defined.
module rvfi_commit_sequencer
   import rvfi_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned DEPTH           = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
   input  logic [riscv::XLEN-1:0]              tohost_addr_i,
   output logic                                trace_valid_o,
   input  logic                                trace_ready_i,
   output rvfi_instr_t                         trace_o,
   output logic [7:0]                          trace_port_o,
   output logic [63:0]                         trace_seq_o,
   output logic                                overflow_o,
   output logic                                done_o,
   output logic [riscv::XLEN-1:0]              exit_code_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]                         count;
   logic [CW-1:0]                         free_cnt;
   logic [CW-1:0]                         cand_cnt;
   logic [CW-1:0]                         wr_num;
   rvfi_seq_entry_t [NR_COMMIT_PORTS-1:0] wr_data;
   rvfi_seq_entry_t                       head;
   logic [NR_COMMIT_PORTS-1:0]            term;
   logic                                  term_hit;
   logic [riscv::XLEN-1:0]                term_data;
   logic                                  cut;
   logic                                  fits;
   logic                                  ingress_open;
   logic                                  wr_en;
   logic                                  pop;

   assign free_cnt = CW'(DEPTH) - count;

`ifdef RVFI_SEQ_TOHOST_EN
   always_comb begin
      term = '0;
      for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
         term[k] = rvfi_i[k].valid
                && ((rvfi_i[k].insn[6:0] == 7'b0100011
                     && (rvfi_i[k].insn[14:12] == 3'b010 || rvfi_i[k].insn[14:12] == 3'b011))
                    || (rvfi_i[k].insn[1:0] == 2'b00 && rvfi_i[k].insn[15:13] == 3'b110)
                    || (riscv::XLEN == 64 && rvfi_i[k].insn[1:0] == 2'b00
                        && rvfi_i[k].insn[15:13] == 3'b111))
                && (rvfi_i[k].mem_addr == tohost_addr_i)
                && (rvfi_i[k].mem_wmask != '0)
                && (rvfi_i[k].mem_wdata != '0)
                && rvfi_i[k].mem_wdata[0]
                && (tohost_addr_i != '0);
      end
   end
`else
   assign term = '0;
`endif

   // Compact candidates into consecutive slots; a terminating store cuts off later ports.
   always_comb begin
      cand_cnt  = '0;
      wr_num    = '0;
      wr_data   = '0;
      term_hit  = 1'b0;
      term_data = '0;
      cut       = 1'b0;
      for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
         if (rvfi_i[k].valid || rvfi_i[k].trap) begin
            cand_cnt = cand_cnt + 1'b1;
            if (!cut) begin
               for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
                  if (CW'(j) == wr_num) begin
                     wr_data[j].instr = rvfi_i[k];
                     wr_data[j].port  = 8'(k);
                  end
               end
               wr_num = wr_num + 1'b1;
               if (term[k]) begin
                  cut       = 1'b1;
                  term_hit  = 1'b1;
                  term_data = rvfi_i[k].mem_wdata;
               end
            end
         end
      end
   end

   assign fits  = (cand_cnt <= free_cnt);
   assign wr_en = fits && ingress_open && (wr_num != '0);
   assign pop   = trace_valid_o && trace_ready_i;

   rvfi_seq_fifo #(
      .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
      .DEPTH           (DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .wr_en   (wr_en),
      .wr_num  (wr_num),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count)
   );

   assign trace_valid_o = (count != '0);
   assign trace_o       = head.instr;
   assign trace_port_o  = head.port;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_o  <= 1'b0;
         trace_seq_o <= '0;
      end else begin
         if (ingress_open && !fits) begin
            overflow_o <= 1'b1;
         end
         if (pop) begin
            trace_seq_o <= trace_seq_o + 64'd1;
         end
      end
   end

`ifdef RVFI_SEQ_TOHOST_EN
   rvfi_seq_state_e state_q;
   rvfi_seq_state_e state_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         exit_code_o <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == RUN && term_hit && fits) begin
            exit_code_o <= term_data;
         end
      end
   end

   // Nothing is written once DRAIN is entered, so an empty queue means the tohost store left.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (term_hit && fits) state_d = DRAIN;
         DRAIN:   if (count == '0) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   assign ingress_open = (state_q == RUN);
   assign done_o       = (state_q == DONE);
`else
   logic unused_nomacro;

   assign unused_nomacro = ^{tohost_addr_i, term_hit, term_data};
   assign ingress_open   = 1'b1;
   assign done_o         = 1'b0;
   assign exit_code_o    = '0;
`endif

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Scoreboard bench for rvfi_commit_sequencer: stimulus pushes expected entries,
// a negedge monitor compares every popped entry against them.
module tb_rvfi_commit_sequencer;
   import rvfi_pkg::*;

   typedef struct {
      logic [63:0] pc;
      logic [7:0]  port;
      logic [63:0] seq;
   } exp_t;

   logic              clk;
   logic              rst_n;
   rvfi_instr_t [1:0] rvfi;
   logic [63:0]       tohost;
   logic              trace_valid;
   logic              trace_ready;
   rvfi_instr_t       trace;
   logic [7:0]        trace_port;
   logic [63:0]       trace_seq;
   logic              overflow;
   logic              done;
   logic [63:0]       exit_code;

   exp_t        sb[$];
   logic [63:0] exp_seq;
   int          total;
   int          bad;

   rvfi_commit_sequencer #(
      .NR_COMMIT_PORTS (2),
      .DEPTH           (8)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rvfi_i        (rvfi),
      .tohost_addr_i (tohost),
      .trace_valid_o (trace_valid),
      .trace_ready_i (trace_ready),
      .trace_o       (trace),
      .trace_port_o  (trace_port),
      .trace_seq_o   (trace_seq),
      .overflow_o    (overflow),
      .done_o        (done),
      .exit_code_o   (exit_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; drives one commit group for one cycle and queues the expected pops.
   task automatic applyStimulus(input logic [1:0] mask, input logic [63:0] pc0,
                                input logic [63:0] pc1, input logic [1:0] exp_mask);
      exp_t e;
      rvfi[0].valid    = mask[0];
      rvfi[0].pc_rdata = pc0;
      rvfi[1].valid    = mask[1];
      rvfi[1].pc_rdata = pc1;
      for (int k = 0; k < 2; k++) begin
         if (exp_mask[k]) begin
            e.pc   = (k == 0) ? pc0 : pc1;
            e.port = 8'(k);
            e.seq  = exp_seq;
            sb.push_back(e);
            exp_seq = exp_seq + 64'd1;
         end
      end
      @(posedge clk);
      #1;
      rvfi = '0;
   endtask

   task automatic setStore(input logic [63:0] data);
      rvfi[0].insn      = 32'h00a5b023;
      rvfi[0].mem_addr  = 64'h8000_1000;
      rvfi[0].mem_wmask = 8'hff;
      rvfi[0].mem_wdata = data;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || trace_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({name, "_drain_timeout"}, 64'(n < 100), 64'd1);
      checkOutput({name, "_drain_valid"}, 64'(trace_valid), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && trace_valid && trace_ready) begin
         if (sb.size() == 0) begin
            checkOutput("pop_unexpected", trace.pc_rdata, 64'hdead_dead_dead_dead);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("pop_pc", trace.pc_rdata, e.pc);
            checkOutput("pop_port", 64'(trace_port), 64'(e.port));
            checkOutput("pop_seq", trace_seq, e.seq);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      total       = 0;
      bad         = 0;
      exp_seq     = '0;
      rst_n       = 1'b0;
      trace_ready = 1'b0;
      rvfi        = '0;
      tohost      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      checkOutput("rst_valid", 64'(trace_valid), 64'd0);
      checkOutput("rst_seq", trace_seq, 64'd0);
      checkOutput("rst_port", 64'(trace_port), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_exit", exit_code, 64'd0);
      checkOutput("rst_trace_zero", 64'(trace == '0), 64'd1);

      // Single commit, one-cycle latency, valid drops after the pop.
      trace_ready = 1'b1;
      applyStimulus(2'b01, 64'h8000_0000, 64'h0, 2'b01);
      checkOutput("single_valid", 64'(trace_valid), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("single_valid_after", 64'(trace_valid), 64'd0);

      // Two ports in one cycle, stalled consumer holds the head stable.
      trace_ready = 1'b0;
      applyStimulus(2'b11, 64'h1000, 64'h1004, 2'b11);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("stall_valid", 64'(trace_valid), 64'd1);
         checkOutput("stall_head_pc", trace.pc_rdata, 64'h1000);
      end
      @(posedge clk);
      #1;
      trace_ready = 1'b1;
      waitDrain("pair");

      // Fill to DEPTH with 2-port groups; the fifth group is dropped.
      trace_ready = 1'b0;
      for (int g = 0; g < 5; g++) begin
         applyStimulus(2'b11, 64'h2000 + 64'(g * 8), 64'h2004 + 64'(g * 8),
                       (g < 4) ? 2'b11 : 2'b00);
      end
      checkOutput("full_overflow", 64'(overflow), 64'd1);
      trace_ready = 1'b1;
      waitDrain("full");
      checkOutput("full_seq_after", trace_seq, 64'd11);

`ifdef RVFI_SEQ_TOHOST_EN
      // Store of an even value to tohost does not terminate.
      tohost = 64'h8000_1000;
      setStore(64'h2);
      applyStimulus(2'b11, 64'h4000, 64'h4004, 2'b11);
      waitDrain("even_store");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("even_done", 64'(done), 64'd0);

      // Detection disabled by a zero tohost address.
      tohost = 64'h0;
      setStore(64'h1);
      rvfi[0].mem_addr = 64'h0;
      applyStimulus(2'b11, 64'h4100, 64'h4104, 2'b11);
      waitDrain("zero_tohost");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("zero_tohost_done", 64'(done), 64'd0);

      // Terminating store on port 0 swallows port 1 and ends the run.
      tohost = 64'h8000_1000;
      setStore(64'h1);
      applyStimulus(2'b11, 64'h4200, 64'h4204, 2'b01);
      checkOutput("term_exit", exit_code, 64'h1);
      waitDrain("term");
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("term_done", 64'(done), 64'd1);
      applyStimulus(2'b01, 64'h4300, 64'h0, 2'b00);
      @(negedge clk);
      checkOutput("term_ingress_closed", 64'(trace_valid), 64'd0);
      checkOutput("term_done_sticky", 64'(done), 64'd1);
`else
      // Without the termination feature a tohost store is an ordinary commit.
      tohost = 64'h8000_1000;
      setStore(64'h1);
      applyStimulus(2'b11, 64'h4000, 64'h4004, 2'b11);
      waitDrain("nomacro_store");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("nomacro_done", 64'(done), 64'd0);
      checkOutput("nomacro_exit", exit_code, 64'd0);
`endif

      // Asynchronous reset with three entries queued.
      trace_ready = 1'b0;
      applyStimulus(2'b11, 64'h5000, 64'h5004, 2'b11);
      applyStimulus(2'b01, 64'h5008, 64'h0, 2'b01);
      checkOutput("pre_rst_valid", 64'(trace_valid), 64'd1);
      rst_n = 1'b0;
      #2;
      checkOutput("mid_rst_valid", 64'(trace_valid), 64'd0);
      checkOutput("mid_rst_seq", trace_seq, 64'd0);
      checkOutput("mid_rst_overflow", 64'(overflow), 64'd0);
      checkOutput("mid_rst_done", 64'(done), 64'd0);
      checkOutput("mid_rst_exit", exit_code, 64'd0);
      checkOutput("mid_rst_trace_zero", 64'(trace == '0), 64'd1);
      sb.delete();
      exp_seq = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      trace_ready = 1'b1;
      tohost      = '0;
      applyStimulus(2'b01, 64'h6000, 64'h0, 2'b01);
      waitDrain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
